// File: rtl/usb_rx_sampler_if.sv
// Pad-side and decoded-bit signals of the USB full-speed receive sampler.
// The master drives enable and raw pads; the slave (sampler) returns decoded bits and line flags.
interface usb_rx_sampler_if;
    logic en;
    logic dp;
    logic dm;
    logic bit_valid;
    logic bit_data;
    logic se0;
    logic stuff_err;
    logic eop;

    modport master (
        output en, dp, dm,
        input  bit_valid, bit_data, se0, stuff_err, eop
    );

    modport slave (
        input  en, dp, dm,
        output bit_valid, bit_data, se0, stuff_err, eop
    );
endinterface

// File: rtl/usb_rx_sampler.sv
// USB FS receive front-end: majority filters on D+/D-, DPLL bit recovery, NRZI decode, bit-unstuffing.
// Define USB_RX_SAMPLER_EOP_EN to build the SE0-count end-of-packet detector (eop is 0 otherwise).
module usb_rx_sampler #(
    parameter int SAMPLES      = 3,
    parameter int OSR          = 4,
    parameter int SAMPLE_PHASE = 2
) (
    input  logic clk,
    input  logic rst,
    usb_rx_sampler_if.slave bus
);
    localparam int PW = $clog2(OSR);
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;

    logic [SAMPLES-1:0] dp_sr;
    logic [SAMPLES-1:0] dm_sr;
    logic [1:0]         line;
    logic [1:0]         line_q;
    logic [1:0]         prev;
    logic [PW-1:0]      phase;
    logic [2:0]         ones;
    logic               fdp;
    logic               fdm;
    logic               trans;
    logic               strobe;
    logic               d;
    logic               bit_valid_r;
    logic               bit_data_r;
    logic               se0_r;
    logic               stuff_err_r;

    function automatic logic majority(input logic [SAMPLES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SAMPLES; i++) n = n + 32'(v[i]);
        return n > SAMPLES / 2;
    endfunction

    assign fdp = majority(dp_sr);
    assign fdm = majority(dm_sr);

    // SE1 carries no information, so it repeats the last registered line state
    assign line   = (fdp && fdm) ? line_q : {fdp, fdm};
    assign trans  = ((line == LINE_J) && (line_q == LINE_K)) ||
                    ((line == LINE_K) && (line_q == LINE_J));
    assign strobe = bus.en && (phase == PW'(SAMPLE_PHASE)) && !trans;
    assign d      = (line == prev);

`ifdef USB_RX_SAMPLER_EOP_EN
    logic [1:0] se0_cnt;
    logic       eop_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sr       <= '1;
            dm_sr       <= '0;
            line_q      <= LINE_J;
            prev        <= LINE_J;
            phase       <= '0;
            ones        <= '0;
            bit_valid_r <= 1'b0;
            bit_data_r  <= 1'b0;
            se0_r       <= 1'b0;
            stuff_err_r <= 1'b0;
`ifdef USB_RX_SAMPLER_EOP_EN
            se0_cnt     <= '0;
            eop_r       <= 1'b0;
`endif
        end else begin
            dp_sr       <= {dp_sr[SAMPLES-2:0], bus.dp};
            dm_sr       <= {dm_sr[SAMPLES-2:0], bus.dm};
            line_q      <= line;
            bit_valid_r <= 1'b0;
            stuff_err_r <= 1'b0;
`ifdef USB_RX_SAMPLER_EOP_EN
            eop_r       <= 1'b0;
`endif
            if (!bus.en) begin
                phase <= '0;
                prev  <= LINE_J;
                ones  <= '0;
                se0_r <= 1'b0;
`ifdef USB_RX_SAMPLER_EOP_EN
                se0_cnt <= '0;
`endif
            end else begin
                if (trans)
                    phase <= PW'(1);
                else if (phase == PW'(OSR - 1))
                    phase <= '0;
                else
                    phase <= phase + PW'(1);

                if (strobe) begin
                    if (line == LINE_SE0) begin
                        se0_r <= 1'b1;
                        prev  <= LINE_J;
                        ones  <= '0;
`ifdef USB_RX_SAMPLER_EOP_EN
                        if (se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
`endif
                    end else begin
                        se0_r <= 1'b0;
                        prev  <= line;
`ifdef USB_RX_SAMPLER_EOP_EN
                        se0_cnt <= '0;
                        if ((line == LINE_J) && (se0_cnt != 2'd0)) begin
                            eop_r <= 1'b1;
                            ones  <= '0;
                        end else
`endif
                        if (ones == 3'd6) begin
                            // a 0 after six 1s is a stuffed bit; a seventh 1 is a violation
                            stuff_err_r <= d;
                            ones        <= '0;
                        end else begin
                            bit_valid_r <= 1'b1;
                            bit_data_r  <= d;
                            ones        <= d ? ones + 3'd1 : 3'd0;
                        end
                    end
                end
            end
        end
    end

    assign bus.bit_valid = bit_valid_r;
    assign bus.bit_data  = bit_data_r;
    assign bus.se0       = se0_r;
    assign bus.stuff_err = stuff_err_r;
`ifdef USB_RX_SAMPLER_EOP_EN
    assign bus.eop       = eop_r;
`else
    assign bus.eop       = 1'b0;
`endif
endmodule

// File: tb/tb_usb_rx_sampler.sv
// Directed bench for usb_rx_sampler at default parameters; cycle numbers are posedges after the
// reference edge where the first line state of each step is driven.
module tb_usb_rx_sampler;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst;
    usb_rx_sampler_if bus ();

    usb_rx_sampler #(.SAMPLES(3), .OSR(4), .SAMPLE_PHASE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   base = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic bv_q[$];
    int   bv_t[$];
    int   serr_n, serr_t, eop_n, eop_t;
    logic se0_log [0:127];
    logic [1:0] sync_pat [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bit_valid) begin
            bv_q.push_back(bus.bit_data);
            bv_t.push_back(cyc - base);
        end
        if (bus.stuff_err) begin serr_n++; serr_t = cyc - base; end
        if (bus.eop) begin eop_n++; eop_t = cyc - base; end
        if ((cyc - base) >= 0 && (cyc - base) < 128) se0_log[cyc - base] = bus.se0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        bv_q.delete();
        bv_t.delete();
        serr_n = 0; serr_t = -1;
        eop_n  = 0; eop_t  = -1;
        foreach (se0_log[i]) se0_log[i] = 1'bx;
    endtask

    function automatic logic [31:0] packed_bits();
        logic [31:0] r;
        r = '0;
        foreach (bv_q[i]) r = {r[30:0], bv_q[i]};
        return r;
    endfunction

    function automatic int last_t();
        return (bv_t.size() > 0) ? bv_t[bv_t.size() - 1] : -1;
    endfunction

    function automatic int first_t();
        return (bv_t.size() > 0) ? bv_t[0] : -1;
    endfunction

    task automatic drive(input logic [1:0] ln, input int n);
        bus.dp = ln[1];
        bus.dm = ln[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.dp = 1'b1;
        bus.dm = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = cyc;
        clear_log();
    endtask

    task automatic finish_step();
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int nz;
        sync_pat = '{K, J, K, J, K, J, K, K};
        clear_log();

        // reset state, then idle J with the receiver enabled
        rst = 1'b1; bus.en = 1'b1; bus.dp = 1'b1; bus.dm = 1'b0;
        @(negedge clk);
        check("rst_bit_valid", 32'(bus.bit_valid), 0);
        check("rst_bit_data",  32'(bus.bit_data),  0);
        check("rst_se0",       32'(bus.se0),       0);
        check("rst_stuff_err", 32'(bus.stuff_err), 0);
        check("rst_eop",       32'(bus.eop),       0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = cyc;
        clear_log();
        repeat (40) @(posedge clk);
        #1;
        check("idle_bv_count", bv_q.size(), 9);
        check("idle_bv_bits",  packed_bits(), 32'h1FF);
        check("idle_first_bv", first_t(), 3);
        check("idle_serr_n",   serr_n, 1);
        check("idle_serr_t",   serr_t, 27);
        nz = 0;
        for (int i = 1; i <= 40; i++) if (se0_log[i] !== 1'b0) nz++;
        check("idle_se0_low", nz, 0);

        // asynchronous reset while a bit_valid pulse is showing
        repeat (3) @(posedge clk);
        #1;
        check("mid_bv_high", 32'(bus.bit_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_bv", 32'(bus.bit_valid), 0);
        check("mid_rst_bd", 32'(bus.bit_data),  0);

        // sync pattern KJKJKJKK; the first edge lands on the strobe phase
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) drive(sync_pat[i], 4);
        drive(K, 1);
        finish_step();
        check("sync_bv_count", bv_q.size(), 8);
        check("sync_bits",     packed_bits(), 32'h01);
        check("sync_first_bv", first_t(), 5);
        check("sync_last_bv",  last_t(), 33);
        check("sync_serr",     serr_n, 0);

        // one-sample glitch on dp inside a J bit
        do_reset();
        bus.en = 1'b1;
        drive(K, 4);
        drive(J, 2);
        drive(SE0, 1);
        drive(J, 1);
        drive(J, 4);
        drive(K, 4);
        drive(K, 1);
        finish_step();
        check("glitch_bv_count", bv_q.size(), 4);
        check("glitch_bits",     packed_bits(), 32'h2);
        check("glitch_last_bv",  last_t(), 17);
        check("glitch_se0",      32'(se0_log[13]), 0);

        // six 1s, stuffed 0, then 1
        do_reset();
        bus.en = 1'b1;
        drive(K, 4);
        drive(K, 24);
        drive(J, 4);
        drive(J, 4);
        drive(J, 1);
        finish_step();
        check("stuff_bv_count", bv_q.size(), 8);
        check("stuff_bits",     packed_bits(), 32'h7F);
        check("stuff_bv6_t",    (bv_t.size() > 6) ? bv_t[6] : -1, 29);
        check("stuff_last_bv",  last_t(), 37);
        check("stuff_serr",     serr_n, 0);

        // slow transmitter: 5 clk per bit, alternating line
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? K : J, 5);
        finish_step();
        check("slow_bv_count", bv_q.size(), 16);
        check("slow_bits",     packed_bits(), 32'h0);
        check("slow_second",   (bv_t.size() > 1) ? bv_t[1] : -1, 10);
        check("slow_last_bv",  last_t(), 80);

        // data, two SE0 bits, then J
        do_reset();
        bus.en = 1'b1;
        drive(K, 4);
        drive(J, 4);
        drive(SE0, 8);
        drive(J, 4);
        drive(J, 1);
        finish_step();
        check("eop_se0_pre",  32'(se0_log[9]),  0);
        check("eop_se0_a",    32'(se0_log[13]), 1);
        check("eop_se0_b",    32'(se0_log[17]), 1);
        check("eop_se0_post", 32'(se0_log[21]), 0);
`ifdef USB_RX_SAMPLER_EOP_EN
        check("eop_bv_count", bv_q.size(), 2);
        check("eop_bits",     packed_bits(), 32'h0);
        check("eop_n",        eop_n, 1);
        check("eop_t",        eop_t, 21);
`else
        check("eop_bv_count", bv_q.size(), 3);
        check("eop_bits",     packed_bits(), 32'h1);
        check("eop_n",        eop_n, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
